// File: rtl/snn_spike_readout.sv
// snn_spike_readout: spike-count readout for an SNN core.
// Counts spikes per output neuron over a window of win_len timesteps, then
// scans the counters one neuron per cycle to find the argmax (lowest index
// wins ties) and holds the result until the consumer accepts it.
// Optional feature: define SNN_READOUT_TOTAL_EN to accumulate a saturating
// 16-bit total of all spikes in the window and present it on res_total.
module snn_spike_readout #(
  parameter int N  = 96,
  parameter int CW = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          win_start,
  input  logic [15:0]   win_len,
  input  logic          step_valid,
  input  logic [N-1:0]  spikes_vec,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [IW-1:0] res_class,
  output logic [CW-1:0] res_count,
  output logic          res_none,
  output logic [15:0]   res_total,
  input  logic [IW-1:0] rb_idx,
  output logic [CW-1:0] rb_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, HOLD} state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW:0]   N_EXT    = (IW + 1)'(N);

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [15:0]   step_ctr_q, step_ctr_d;
  logic [15:0]   len_q, len_d;
  logic [IW-1:0] scan_idx_q, scan_idx_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d;
  logic [IW-1:0] res_class_q, res_class_d;
  logic [CW-1:0] res_count_q, res_count_d;
  logic          res_none_q, res_none_d;

  logic          win_clear;
  logic          acc_step;
  logic          last_step;
  logic          scan_last;
  logic [CW-1:0] scan_cnt;
  logic          scan_better;
  logic [IW-1:0] cand_idx;
  logic [CW-1:0] cand_cnt;

  // Qualify control events by state; a restart in ACCUM swallows that cycle's step.
  always_comb begin
    win_clear   = win_start && ((state_q == IDLE) || (state_q == ACCUM));
    acc_step    = (state_q == ACCUM) && step_valid && !win_start;
    last_step   = (step_ctr_q + 16'd1) == len_q;
    scan_last   = scan_idx_q == LAST_IDX;
    scan_cnt    = cnt_q[scan_idx_q];
    scan_better = scan_cnt > best_cnt_q;
    cand_idx    = scan_better ? scan_idx_q : best_idx_q;
    cand_cnt    = scan_better ? scan_cnt : best_cnt_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_start) state_d = ACCUM;
      ACCUM: begin
        if (win_start) begin
          state_d = ACCUM;
        end else if (step_valid && last_step) begin
          state_d = SCAN;
        end
      end
      SCAN:    if (scan_last) state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy      = (state_q == ACCUM) || (state_q == SCAN);
    res_valid = (state_q == HOLD);
  end

  // Per-neuron saturating counters; cleared only by an accepted win_start.
  always_comb begin
    for (int unsigned n = 0; n < N; n++) begin
      cnt_d[n] = cnt_q[n];
      if (win_clear) begin
        cnt_d[n] = '0;
      end else if (acc_step && spikes_vec[n] && (cnt_q[n] != '1)) begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  // Counter storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned n = 0; n < N; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < N; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  // Window bookkeeping, argmax scan and result capture.
  always_comb begin
    step_ctr_d  = step_ctr_q;
    len_d       = len_q;
    scan_idx_d  = scan_idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    res_class_d = res_class_q;
    res_count_d = res_count_q;
    res_none_d  = res_none_q;
    if (win_clear) begin
      step_ctr_d = '0;
      len_d      = (win_len == 16'd0) ? 16'd1 : win_len;
    end else if (acc_step) begin
      step_ctr_d = step_ctr_q + 16'd1;
      if (last_step) begin
        scan_idx_d = '0;
        best_idx_d = '0;
        best_cnt_d = '0;
      end
    end else if (state_q == SCAN) begin
      scan_idx_d = scan_idx_q + 1'b1;
      best_idx_d = cand_idx;
      best_cnt_d = cand_cnt;
      // The final comparison feeds the result directly so HOLD starts N edges after the last step.
      if (scan_last) begin
        res_class_d = cand_idx;
        res_count_d = cand_cnt;
        res_none_d  = (cand_cnt == '0);
      end
    end
  end

  // Window and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_ctr_q  <= '0;
      len_q       <= 16'd1;
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      res_class_q <= '0;
      res_count_q <= '0;
      res_none_q  <= 1'b0;
    end else begin
      step_ctr_q  <= step_ctr_d;
      len_q       <= len_d;
      scan_idx_q  <= scan_idx_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      res_class_q <= res_class_d;
      res_count_q <= res_count_d;
      res_none_q  <= res_none_d;
    end
  end

  assign res_class = res_class_q;
  assign res_count = res_count_q;
  assign res_none  = res_none_q;

`ifdef SNN_READOUT_TOTAL_EN
  logic [15:0] total_q, total_d;
  logic [15:0] res_total_q, res_total_d;
  logic [15:0] pop;
  logic [16:0] total_sum;

  // Window-wide spike total, saturating at 16 bits.
  always_comb begin
    pop = '0;
    for (int unsigned n = 0; n < N; n++) begin
      pop = pop + {15'd0, spikes_vec[n]};
    end
    total_sum   = {1'b0, total_q} + {1'b0, pop};
    total_d     = total_q;
    res_total_d = res_total_q;
    if (win_clear) begin
      total_d = '0;
    end else if (acc_step) begin
      total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
    if ((state_q == SCAN) && scan_last) begin
      res_total_d = total_q;
    end
  end

  // Total and its presented copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      total_q     <= '0;
      res_total_q <= '0;
    end else begin
      total_q     <= total_d;
      res_total_q <= res_total_d;
    end
  end

  assign res_total = res_total_q;
`else
  assign res_total = '0;
`endif

  // Combinational counter readback; indices past the last neuron read as zero.
  always_comb begin
    rb_count = '0;
    if ({1'b0, rb_idx} < N_EXT) begin
      rb_count = cnt_q[rb_idx];
    end
  end

endmodule

// File: tb/tb_snn_spike_readout.sv
// Self-checking bench for snn_spike_readout (N=96, CW=8): directed windows
// with hand-computed results pushed to a scoreboard queue; a monitor pops
// and compares whenever res_valid rises.
`timescale 1ns/1ps
module tb_snn_spike_readout;

  localparam int N  = 96;
  localparam int CW = 8;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rstn;
  logic          win_start;
  logic [15:0]   win_len;
  logic          step_valid;
  logic [N-1:0]  spikes_vec;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [IW-1:0] res_class;
  logic [CW-1:0] res_count;
  logic          res_none;
  logic [15:0]   res_total;
  logic [IW-1:0] rb_idx;
  logic [CW-1:0] rb_count;

  snn_spike_readout #(.N(N), .CW(CW), .IW(IW)) dut (
    .clk(clk), .rstn(rstn), .win_start(win_start), .win_len(win_len),
    .step_valid(step_valid), .spikes_vec(spikes_vec), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_count(res_count), .res_none(res_none), .res_total(res_total),
    .rb_idx(rb_idx), .rb_count(rb_count)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    int cls;
    int cnt;
    int none;
    int tot;
    int k;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int tot_exp(input int x);
`ifdef SNN_READOUT_TOTAL_EN
    return x;
`else
    return 0;
`endif
  endfunction

  function automatic logic [N-1:0] hot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic push_exp(input int cls, input int cnt, input int none, input int tot, input int k);
    exp_t e;
    e.cls = cls; e.cnt = cnt; e.none = none; e.tot = tot; e.k = k;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the scoreboard head against each newly presented result.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got class %0d with no expected entry", res_class);
        end else begin
          e = exp_q.pop_front();
          chk("res_class", int'(res_class), e.cls);
          chk("res_count", int'(res_count), e.cnt);
          chk("res_none", int'(res_none), e.none);
          chk("res_total", int'(res_total), e.tot);
          chk("latency_edges", edge_no - e.k, N);
        end
      end
      prev = res_valid;
    end
  end

  task automatic start_win(input int len);
    win_start = 1'b1;
    win_len   = 16'(len);
    @(negedge clk);
    win_start = 1'b0;
  endtask

  task automatic do_step(input logic [N-1:0] s);
    step_valid = 1'b1;
    spikes_vec = s;
    @(negedge clk);
    step_valid = 1'b0;
    spikes_vec = '0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got timeout after %0d cycles expected res_valid=1", n);
    end
  endtask

  task automatic accept();
    wait_valid();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic rb_chk(input string name, input int idx, input int expv);
    rb_idx = IW'(idx);
    #1;
    chk(name, int'(rb_count), expv);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected completion within 1 ms");
    $fatal(1);
  end

  initial begin : stim
    int k;
    int nz;
    rstn = 1'b0; win_start = 1'b0; win_len = '0; step_valid = 1'b0;
    spikes_vec = '0; res_ready = 1'b0; rb_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_class", int'(res_class), 0);
    chk("rst_res_count", int'(res_count), 0);
    chk("rst_res_none", int'(res_none), 0);
    chk("rst_res_total", int'(res_total), 0);
    rb_chk("rst_rb7", 7, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Window A: neuron 7 on 4 steps, neuron 50 on 2.
    start_win(4);
    chk("accum_busy", int'(busy), 1);
    do_step(hot(7) | hot(50));
    do_step(hot(7) | hot(50));
    do_step(hot(7));
    do_step(hot(7));
    k = edge_no;
    push_exp(7, 4, 0, tot_exp(6), k);
    wait_valid();
    // Hold for 20 cycles; a win_start and step inside HOLD must be ignored.
    for (int i = 0; i < 20; i++) begin
      win_start  = (i == 5);
      win_len    = 16'd9;
      step_valid = (i == 6);
      spikes_vec = hot(1);
      @(negedge clk);
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_class", int'(res_class), 7);
      chk("hold_count", int'(res_count), 4);
      chk("hold_busy", int'(busy), 0);
    end
    win_start = 1'b0; step_valid = 1'b0; spikes_vec = '0;
    rb_chk("rb_n7", 7, 4);
    rb_chk("rb_n50", 50, 2);
    rb_chk("rb_n1", 1, 0);
    rb_chk("rb_oob", 100, 0);
    // Handshake together with win_start: back to IDLE, win_start ignored.
    res_ready = 1'b1;
    win_start = 1'b1;
    win_len   = 16'd5;
    @(negedge clk);
    res_ready = 1'b0;
    win_start = 1'b0;
    chk("hs_valid", int'(res_valid), 0);
    chk("hs_busy", int'(busy), 0);
    rb_chk("kept_n7", 7, 4);

    // Window B: restart inside ACCUM, then neurons 10 and 20 tie on 3.
    start_win(3);
    do_step(hot(30));
    win_start  = 1'b1;
    win_len    = 16'd3;
    step_valid = 1'b1;
    spikes_vec = hot(30);
    @(negedge clk);
    win_start = 1'b0; step_valid = 1'b0; spikes_vec = '0;
    do_step(hot(10) | hot(20));
    do_step(hot(10) | hot(20));
    do_step(hot(10) | hot(20));
    k = edge_no;
    push_exp(10, 3, 0, tot_exp(6), k);
    accept();
    rb_chk("restart_n30", 30, 0);
    rb_chk("tie_n20", 20, 3);

    // Window C: 300 steps of neuron 5 saturates its counter.
    start_win(300);
    for (int i = 0; i < 300; i++) do_step(hot(5));
    k = edge_no;
    push_exp(5, 255, 0, tot_exp(300), k);
    accept();

    // Window D: no spikes at all.
    start_win(2);
    do_step('0);
    do_step('0);
    k = edge_no;
    push_exp(0, 0, 1, 0, k);
    accept();

    // Window G: win_len=0 behaves as a single step; the next step is ignored.
    start_win(0);
    do_step(hot(3));
    k = edge_no;
    push_exp(3, 1, 0, tot_exp(1), k);
    do_step(hot(3));
    accept();
    rb_chk("len0_n3", 3, 1);

    // Reset during SCAN aborts without a result and clears every counter.
    start_win(1);
    do_step(hot(40) | hot(41));
    repeat (10) @(negedge clk);
    chk("scan_busy", int'(busy), 1);
    rstn = 1'b0;
    #1;
    chk("abort_valid", int'(res_valid), 0);
    chk("abort_busy", int'(busy), 0);
    nz = 0;
    for (int i = 0; i < N; i++) begin
      rb_idx = IW'(i);
      #1;
      if (rb_count != '0) nz++;
    end
    chk("abort_rb_nonzero", nz, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (150) @(negedge clk);
    chk("abort_no_result", int'(res_valid), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
